// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
//   Shared definitions for the instruction fetch stage.
//   - NPC_* : next-PC select codes, the same encodings the control unit
//             drives on pc_sel.
//   - sign_ext16 : 16-to-32-bit sign extension used for branch offsets.
package fetch_unit_pkg;

   localparam logic [1:0] NPC_PLUS4  = 2'b00;
   localparam logic [1:0] NPC_BRANCH = 2'b01;
   localparam logic [1:0] NPC_JUMP   = 2'b10;
   localparam logic [1:0] NPC_JUMPR  = 2'b11;

   function automatic logic [31:0] sign_ext16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

endpackage

// File: rtl/fetch_unit_npc_calc.sv
// fetch_unit_npc_calc
//   Combinational next-PC computation for the fetch stage.
//   Ports:
//     pc_plus4     in  32  address of the instruction after the current one
//     instr_index  in  26  instr[25:0] of the current instruction
//     pc_sel       in   2  NPC_* select from the control unit
//     rs_data      in  32  register target for NPC_JUMPR
//     npc          out 32  next PC (32-bit modulo arithmetic, silent wrap)
module fetch_unit_npc_calc
   import fetch_unit_pkg::*;
(
   input  logic [31:0] pc_plus4,
   input  logic [25:0] instr_index,
   input  logic [1:0]  pc_sel,
   input  logic [31:0] rs_data,
   output logic [31:0] npc
);

   logic [31:0] branch_target;
   logic [31:0] jump_target;

   // Branch offset is a word offset relative to the delay-free pc+4.
   assign branch_target = pc_plus4 + (sign_ext16(instr_index[15:0]) << 2);
   // Jump stays inside the 256 MB region of pc+4.
   assign jump_target   = {pc_plus4[31:28], instr_index, 2'b00};

   always_comb begin
      npc = pc_plus4;
      case (pc_sel)
         NPC_PLUS4:  npc = pc_plus4;
         NPC_BRANCH: npc = branch_target;
         NPC_JUMP:   npc = jump_target;
         NPC_JUMPR:  npc = rs_data;
      endcase
   end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage: holds the PC, fetches from a variable-latency
//   instruction memory, presents the decoded fields until the datapath
//   retires the instruction, then steps to the next PC.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     imem_req/addr            fetch request (held until imem_ready), address
//     imem_ready/rdata         memory response and instruction word
//     pc_sel, rs_data          next-PC select and register jump target
//     advance                  datapath retires the current instruction
//     pc, pc_plus4             current instruction address and link value
//     instr, instr_valid       instruction register and its valid flag
//     opcode..imm16            decoded instruction fields
//     addr_err                 sticky misaligned-next-PC flag (cleared by rst)
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
)(
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   input  logic [1:0]  pc_sel,
   input  logic [31:0] rs_data,
   input  logic        advance,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [5:0]  opcode,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [4:0]  shamt,
   output logic [5:0]  funct,
   output logic [15:0] imm16,
   output logic        addr_err
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;
   localparam logic [1:0] ST_ERR   = 2'd3;

   logic [1:0]  state_reg;
   logic [31:0] pc_reg;
   logic [31:0] instr_reg;
   logic [31:0] npc;

   fetch_unit_npc_calc npc_calc (
      .pc_plus4    (pc_plus4),
      .instr_index (instr_reg[25:0]),
      .pc_sel      (pc_sel),
      .rs_data     (rs_data),
      .npc         (npc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         pc_reg    <= RESET_PC;
         instr_reg <= '0;
      end else begin
         case (state_reg)
            ST_IDLE:  state_reg <= ST_FETCH;
            ST_FETCH: begin
               if (imem_ready) begin
                  instr_reg <= imem_rdata;
                  state_reg <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (advance) begin
                  // The misaligned PC is kept so it can be inspected after the fault.
                  pc_reg    <= npc;
                  state_reg <= (npc[1:0] != 2'b00) ? ST_ERR : ST_FETCH;
               end
            end
            ST_ERR:   state_reg <= ST_ERR;
         endcase
      end
   end

   // All status outputs are pure decodes of the state, so ERR is sticky
   // until reset without a separate flag register.
   assign imem_req    = (state_reg == ST_FETCH);
   assign instr_valid = (state_reg == ST_HOLD);
   assign addr_err    = (state_reg == ST_ERR);

   assign pc        = pc_reg;
   assign imem_addr = pc_reg;
   assign pc_plus4  = pc_reg + 32'd4;
   assign instr     = instr_reg;

   assign opcode = instr_reg[31:26];
   assign rs     = instr_reg[25:21];
   assign rt     = instr_reg[20:16];
   assign rd     = instr_reg[15:11];
   assign shamt  = instr_reg[10:6];
   assign funct  = instr_reg[5:0];
   assign imm16  = instr_reg[15:0];

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Directed test-plan sequence with literal expectations, then randomized
//   memory latency / retire / next-PC traffic. A transaction-level model of
//   the fetch stage predicts every output and is compared on each negedge.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [1:0]  pc_sel = 2'b00;
   logic [31:0] rs_data = '0;
   logic        advance = 1'b0;
   logic [31:0] pc, pc_plus4, instr;
   logic        instr_valid;
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm16;
   logic        addr_err;

   fetch_unit dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata), .pc_sel(pc_sel),
      .rs_data(rs_data), .advance(advance), .pc(pc), .pc_plus4(pc_plus4),
      .instr(instr), .instr_valid(instr_valid), .opcode(opcode), .rs(rs),
      .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm16(imm16),
      .addr_err(addr_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Phases of an instruction's life: waiting to start, being fetched,
   // waiting to retire, and dead after a misaligned target.
   localparam int M_IDLE = 0, M_FETCH = 1, M_HOLD = 2, M_ERR = 3;
   int          m_mode  = M_IDLE;
   logic [31:0] m_pc    = 32'h0000_3000;
   logic [31:0] m_instr = '0;
   bit          m_live  = 0;   // model is meaningful once reset was seen

   function automatic logic [31:0] model_npc(input logic [31:0] cur_pc, input logic [31:0] ins,
                                             input logic [1:0] sel, input logic [31:0] rsd);
      logic [31:0] seq;
      int signed   off;
      seq = cur_pc + 32'd4;
      off = int'($signed(ins[15:0])) * 4;
      case (sel)
         2'b00:   return seq;
         2'b01:   return seq + 32'(off);
         2'b10:   return {seq[31:28], ins[25:0], 2'b00};
         default: return rsd;
      endcase
   endfunction

   always @(posedge clk) begin
      logic [31:0] n;
      if (rst) begin
         m_mode  = M_IDLE;
         m_pc    = 32'h0000_3000;
         m_instr = '0;
         m_live  = 1;
      end else if (m_mode == M_IDLE) begin
         m_mode = M_FETCH;
      end else if (m_mode == M_FETCH && imem_ready) begin
         m_instr = imem_rdata;
         m_mode  = M_HOLD;
      end else if (m_mode == M_HOLD && advance) begin
         n      = model_npc(m_pc, m_instr, pc_sel, rs_data);
         m_pc   = n;
         m_mode = (n % 4 != 0) ? M_ERR : M_FETCH;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (m_live) begin
         check("imem_req",    32'(imem_req),    32'(m_mode == M_FETCH));
         check("instr_valid", 32'(instr_valid), 32'(m_mode == M_HOLD));
         check("addr_err",    32'(addr_err),    32'(m_mode == M_ERR));
         check("pc",          pc,               m_pc);
         check("imem_addr",   imem_addr,        m_pc);
         check("pc_plus4",    pc_plus4,         m_pc + 32'd4);
         check("instr",       instr,            m_instr);
         check("fields",      {opcode, rs, rt, rd, shamt, funct},
                              m_instr);
         check("imm16",       32'(imm16),       m_instr & 32'h0000_FFFF);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      imem_ready = 0; advance = 0; pc_sel = 2'b00; rs_data = '0;
   endtask

   initial begin
      // 1. reset, zero-wait fetch of addi $t0,$zero,5
      rst = 1; tick(); tick();
      check("rst_pc",          pc,                 32'h0000_3000);
      check("rst_instr",       instr,              32'h0);
      check("rst_req_valid",   {imem_req, instr_valid, addr_err}, 3'b000);
      rst = 0; tick();
      check("t1_req",          32'(imem_req),      32'd1);
      check("t1_addr",         imem_addr,          32'h0000_3000);
      imem_ready = 1; imem_rdata = 32'h2008_0005; tick();
      check("t1_valid",        32'(instr_valid),   32'd1);
      check("t1_opcode",       32'(opcode),        32'h08);
      check("t1_rt",           32'(rt),            32'd8);
      check("t1_imm16",        32'(imm16),         32'h0005);
      // 2. sequential advance
      imem_ready = 0; pc_sel = 2'b00; advance = 1; tick();
      advance = 0;
      check("t2_addr",         imem_addr,          32'h0000_3004);
      check("t2_valid",        32'(instr_valid),   32'd0);
      // 3. branch to self
      imem_ready = 1; imem_rdata = 32'h1000_FFFF; tick();
      imem_ready = 0; pc_sel = 2'b01; advance = 1; tick();
      advance = 0;
      check("t3_addr",         imem_addr,          32'h0000_3004);
      // 4. step to 0x3008, jump, then misaligned jr
      imem_ready = 1; imem_rdata = 32'h0000_0000; tick();
      imem_ready = 0; pc_sel = 2'b00; advance = 1; tick();
      advance = 0;
      check("t4_seq_addr",     imem_addr,          32'h0000_3008);
      imem_ready = 1; imem_rdata = 32'h0800_0C10; tick();
      imem_ready = 0; pc_sel = 2'b10; advance = 1; tick();
      advance = 0;
      check("t4_jump_addr",    imem_addr,          32'h0000_3040);
      imem_ready = 1; imem_rdata = 32'h03E0_0008; tick();
      imem_ready = 0; pc_sel = 2'b11; rs_data = 32'h0000_3002; advance = 1; tick();
      check("t4_err",          32'(addr_err),      32'd1);
      check("t4_err_req",      32'(imem_req),      32'd0);
      imem_ready = 1; for (int i = 0; i < 3; i++) tick();
      check("t4_err_sticky",   {imem_req, addr_err}, 2'b01);
      check("t4_err_pc",       pc,                 32'h0000_3002);
      idle_inputs();
      // 5. slow memory, advance ignored during FETCH
      rst = 1; tick(); rst = 0; tick();
      advance = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t5_req_held",  32'(imem_req),      32'd1);
      end
      imem_ready = 1; imem_rdata = 32'hDEAD_BEEF; tick();
      imem_ready = 0; advance = 0;
      check("t5_instr",        instr,              32'hDEAD_BEEF);
      check("t5_pc",           pc,                 32'h0000_3000);
      // 6. reset abandons a pending fetch; late ready dropped in IDLE
      advance = 1; tick(); advance = 0; tick();
      rst = 1; tick();
      check("t6_pc",           pc,                 32'h0000_3000);
      check("t6_instr",        instr,              32'h0);
      check("t6_valid",        32'(instr_valid),   32'd0);
      rst = 0; imem_ready = 1; imem_rdata = 32'hBAD0_BAD0; tick();
      imem_ready = 0;
      check("t6_junk_dropped", instr,              32'h0);
      check("t6_fetch_req",    32'(imem_req),      32'd1);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst        = (m_mode == M_ERR && $urandom_range(0, 3) == 0) || ($urandom_range(0, 399) == 0);
         imem_ready = ($urandom_range(0, 2) != 0);
         imem_rdata = $urandom;
         advance    = ($urandom_range(0, 1) == 1);
         pc_sel     = 2'($urandom_range(0, 3));
         rs_data    = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
         tick();
      end
      rst = 0; idle_inputs(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
